// File: rtl/thirtytwobit_adder.sv
// Ripple-carry adder built from one-bit full-adder cells, with registered copies of sum and carry.
// Define THIRTYTWOBIT_ADDER_OVF_EN to add the signed-overflow outputs overflow / overflow_q.

module thirtytwobit_adder_fa (
   input  logic i_a,
   input  logic i_b,
   input  logic i_cin,
   output logic o_sum,
   output logic o_cout,
   output logic o_and,
   output logic o_or
);
   logic w_half;

   assign w_half = i_a ^ i_b;
   assign o_sum  = w_half ^ i_cin;
   assign o_cout = (i_a & i_b) | (i_cin & w_half);
   assign o_and  = i_a & i_b;
   assign o_or   = i_a | i_b;
endmodule

module thirtytwobit_adder #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             carry_in,
   output logic [WIDTH-1:0] Result,
   output logic             carry_out,
   output logic [WIDTH-1:0] gen,
   output logic [WIDTH-1:0] prop,
`ifdef THIRTYTWOBIT_ADDER_OVF_EN
   output logic             overflow,
   output logic             overflow_q,
`endif
   output logic [WIDTH-1:0] result_q,
   output logic             carry_q
);
   // w_carry[i] is the carry into bit i; w_carry[WIDTH] leaves the top cell.
   logic [WIDTH:0]   w_carry;
   logic [WIDTH-1:0] w_sum;
   logic [WIDTH-1:0] r_result_q;
   logic             r_carry_q;

   assign w_carry[0] = carry_in;

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      thirtytwobit_adder_fa u_fa (
         .i_a    (A[gi]),
         .i_b    (B[gi]),
         .i_cin  (w_carry[gi]),
         .o_sum  (w_sum[gi]),
         .o_cout (w_carry[gi+1]),
         .o_and  (gen[gi]),
         .o_or   (prop[gi])
      );
   end

   assign Result    = w_sum;
   assign carry_out = w_carry[WIDTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_result_q <= '0;
         r_carry_q  <= 1'b0;
      end else begin
         r_result_q <= w_sum;
         r_carry_q  <= w_carry[WIDTH];
      end
   end

   assign result_q = r_result_q;
   assign carry_q  = r_carry_q;

`ifdef THIRTYTWOBIT_ADDER_OVF_EN
   // Signed overflow: like-signed operands producing a result of the opposite sign.
   logic w_overflow;
   logic r_overflow_q;

   assign w_overflow = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_overflow_q <= 1'b0;
      else        r_overflow_q <= w_overflow;
   end

   assign overflow   = w_overflow;
   assign overflow_q = r_overflow_q;
`endif
endmodule

// File: tb/tb_thirtytwobit_adder.sv
// Directed self-checking bench for thirtytwobit_adder; overflow checks follow THIRTYTWOBIT_ADDER_OVF_EN.

module tb_thirtytwobit_adder;
   logic        clk;
   logic        rst_n;
   logic [31:0] A;
   logic [31:0] B;
   logic        carry_in;
   logic [31:0] Result;
   logic        carry_out;
   logic [31:0] gen;
   logic [31:0] prop;
   logic [31:0] result_q;
   logic        carry_q;
`ifdef THIRTYTWOBIT_ADDER_OVF_EN
   logic        overflow;
   logic        overflow_q;
`endif

   int n_cmp;
   int n_err;

   thirtytwobit_adder #(.WIDTH(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .A          (A),
      .B          (B),
      .carry_in   (carry_in),
      .Result     (Result),
      .carry_out  (carry_out),
      .gen        (gen),
      .prop       (prop),
`ifdef THIRTYTWOBIT_ADDER_OVF_EN
      .overflow   (overflow),
      .overflow_q (overflow_q),
`endif
      .result_q   (result_q),
      .carry_q    (carry_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic cin);
      @(negedge clk);
      A        = a;
      B        = b;
      carry_in = cin;
      #1;
   endtask

   task automatic check_sum(input string tag, input logic [31:0] exp_r, input logic exp_c);
      check({tag, "_result"}, Result, exp_r);
      check({tag, "_carry"}, {31'b0, carry_out}, {31'b0, exp_c});
      @(posedge clk);
      #1;
      check({tag, "_result_q"}, result_q, exp_r);
      check({tag, "_carry_q"}, {31'b0, carry_q}, {31'b0, exp_c});
   endtask

   initial begin
      logic [7:0] sum_tt;
      logic [7:0] cout_tt;
      logic       ea;
      logic       eb;
      logic       ec;
      n_cmp    = 0;
      n_err    = 0;
      rst_n    = 1'b0;
      A        = 32'h0000_0000;
      B        = 32'h0000_0000;
      carry_in = 1'b0;

      // Reset state, with clocks running
      repeat (2) @(posedge clk);
      #1;
      check("rst_result_q", result_q, 32'h0);
      check("rst_carry_q", {31'b0, carry_q}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors
      drive(32'ha0ced587, 32'haca69a1b, 1'b0);
`ifdef THIRTYTWOBIT_ADDER_OVF_EN
      check("v1_overflow", {31'b0, overflow}, 32'h1);
`endif
      check_sum("v1", 32'h4d756fa2, 1'b1);
`ifdef THIRTYTWOBIT_ADDER_OVF_EN
      check("v1_overflow_q", {31'b0, overflow_q}, 32'h1);
`endif

      drive(32'hd6f28b79, 32'h449a9035, 1'b0);
`ifdef THIRTYTWOBIT_ADDER_OVF_EN
      check("v2_overflow", {31'b0, overflow}, 32'h0);
`endif
      check_sum("v2", 32'h1b8d1bae, 1'b1);

      drive(32'he2bb5641, 32'h1e0049d5, 1'b0);
      check_sum("v3", 32'h00bba016, 1'b1);

      drive(32'h04361d9c, 32'h1023104d, 1'b0);
      check_sum("v4", 32'h14592de9, 1'b0);

      drive(32'hffffffff, 32'h00000000, 1'b1);
      check("v5_gen", gen, 32'h00000000);
      check("v5_prop", prop, 32'hffffffff);
      check_sum("v5", 32'h00000000, 1'b1);

      drive(32'h7fffffff, 32'h00000001, 1'b0);
`ifdef THIRTYTWOBIT_ADDER_OVF_EN
      check("v6_overflow", {31'b0, overflow}, 32'h1);
`endif
      check_sum("v6", 32'h80000000, 1'b0);

      drive(32'hffffffff, 32'hffffffff, 1'b1);
      check("v7_gen", gen, 32'hffffffff);
      check_sum("v7", 32'hffffffff, 1'b1);

      drive(32'h00000000, 32'h00000000, 1'b0);
      check_sum("v8", 32'h00000000, 1'b0);

      drive(32'h5a5a0f0f, 32'h3c3cff00, 1'b0);
      check("v9_gen", gen, 32'h18180f00);
      check("v9_prop", prop, 32'h7e7eff0f);

      // One-bit cell truth table through bit 0; bit 1 exposes its carry out
      sum_tt  = 8'b1001_0110;
      cout_tt = 8'b1110_1000;
      for (int v = 0; v < 8; v++) begin
         ea = v[0];
         eb = v[1];
         ec = v[2];
         drive({31'b0, ea}, {31'b0, eb}, ec);
         check($sformatf("cell%0d_sum_cout", v), Result, {30'b0, cout_tt[v], sum_tt[v]});
         check($sformatf("cell%0d_and", v), gen, {31'b0, ea & eb});
         check($sformatf("cell%0d_or", v), prop, {31'b0, ea | eb});
      end

      // Asynchronous reset between edges
      drive(32'h12345678, 32'hf0000000, 1'b0);
      @(posedge clk);
      #1;
      check("pre_rst_result_q", result_q, 32'h02345678);
      check("pre_rst_carry_q", {31'b0, carry_q}, 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_result_q", result_q, 32'h0);
      check("async_rst_carry_q", {31'b0, carry_q}, 32'h0);
      check("async_rst_result_comb", Result, 32'h02345678);
      A = 32'h00000010;
      B = 32'h00000020;
      #1;
      check("rst_comb_tracks", Result, 32'h00000030);
      @(posedge clk);
      #1;
      check("rst_hold_result_q", result_q, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rel_before_edge", result_q, 32'h0);
      @(posedge clk);
      #1;
      check("rel_first_edge", result_q, 32'h00000030);
      check("rel_first_edge_carry", {31'b0, carry_q}, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
